// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port, combinational-read
// memory. Each transaction runs IDLE -> ACCESS -> RESP, one every three cycles.
module mem_arbiter #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        sel_q, sel_d;
  logic        oor_q, oor_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        grant1;
  logic        req_we;
  logic        req_oor;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] read_data;

  always_comb begin
    // last_q = 1 means master 1 was served last, so master 0 wins a tie
    grant1    = req1 & (~req0 | ~last_q);
    req_we    = grant1 ? we1 : we0;
    req_addr  = grant1 ? addr1 : addr0;
    req_wdata = grant1 ? wdata1 : wdata0;
    req_oor   = (req_addr[31:AW] != '0) || (req_addr >= 32'(DEPTH));
    read_data = mem_read_q ? mem_rdata : 32'd0;

    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    oor_d       = oor_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    done0_d     = done0_q;
    done1_d     = done1_q;
    err0_d      = err0_q;
    err1_d      = err1_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d     = ACCESS;
          last_d      = grant1;
          sel_d       = grant1;
          oor_d       = req_oor;
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata;
          mem_read_d  = ~req_we & ~req_oor;
          mem_write_d = req_we & ~req_oor;
        end
      end
      ACCESS: begin
        state_d     = RESP;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (sel_q) begin
          done1_d  = 1'b1;
          err1_d   = oor_q;
          rdata1_d = read_data;
        end else begin
          done0_d  = 1'b1;
          err0_d   = oor_q;
          rdata0_d = read_data;
        end
      end
      RESP: begin
        state_d  = IDLE;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rdata0_d = 32'd0;
        rdata1_d = 32'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      oor_q       <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= 32'd0;
      rdata1_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      oor_q       <= oor_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, two master agents and a
// transaction-level reference model (grant edge, done edge, shadow memory).
module tb_mem_arbiter;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        done0, done1, err0, err1, mem_read, mem_write, busy;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic        preload = 1'b1;
  logic [31:0] mem [DEPTH];

  mem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = 32'(i);
    return (i == 5) ? 32'hDEADBEEF : (w * 32'h9E3779B1 + 32'h0000_1234);
  endfunction

  assign mem_rdata = mem[mem_addr[AW-1:0]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (mem_write) begin
      mem[mem_addr[AW-1:0]] <= mem_wdata;
    end
  end

  int          err_count = 0, check_count = 0;
  int          edge_n = 0, free_edge = 0, wr_seen = 0, rd_seen = 0;
  bit          random_mode = 1'b0;
  bit          last_served = 1'b1;
  bit          pend [2], keep [2], p_we [2];
  logic [31:0] p_addr [2], p_wdata [2];
  logic [31:0] ref_mem [DEPTH];
  bit          cur_valid = 1'b0, cur_m, cur_we, cur_oor;
  int          cur_g = 0;
  logic [31:0] cur_addr, cur_wdata, cur_rdata;
  logic [31:0] exp_mem_addr = '0, exp_mem_wdata = '0;
  int          obs_m [$], obs_edge [$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s at edge %0d: got 0x%08h, expected 0x%08h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic set_txn(input int m, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    pend[m] = 1'b1; p_we[m] = we; p_addr[m] = addr; p_wdata[m] = wdata;
  endtask

  task automatic gen_txn(input int m);
    int sel;
    logic [31:0] a;
    sel = $urandom_range(0, 7);
    if (sel == 0)      a = 32'(DEPTH) + 32'($urandom_range(0, 3));
    else if (sel == 1) a = $urandom | 32'h8000_0000;
    else               a = 32'($urandom_range(0, 31));
    set_txn(m, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  task automatic applyStimulus();
    if (random_mode) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 1) == 1) gen_txn(m);
    end
    // an idle master may wiggle its other inputs freely
    req0   = pend[0];
    we0    = pend[0] ? p_we[0]    : 1'($urandom);
    addr0  = pend[0] ? p_addr[0]  : $urandom;
    wdata0 = pend[0] ? p_wdata[0] : $urandom;
    req1   = pend[1];
    we1    = pend[1] ? p_we[1]    : 1'($urandom);
    addr1  = pend[1] ? p_addr[1]  : $urandom;
    wdata1 = pend[1] ? p_wdata[1] : $urandom;
  endtask

  task automatic model_grant(input int e);
    bit m;
    m = (pend[0] && pend[1]) ? !last_served : pend[1];
    last_served = m;
    cur_valid = 1'b1; cur_g = e; cur_m = m;
    cur_we = p_we[m]; cur_addr = p_addr[m]; cur_wdata = p_wdata[m];
    cur_oor = (cur_addr >= 32'(DEPTH));
    cur_rdata = (!cur_we && !cur_oor) ? ref_mem[cur_addr[AW-1:0]] : 32'd0;
    if (cur_we && !cur_oor) ref_mem[cur_addr[AW-1:0]] = cur_wdata;
    exp_mem_addr = cur_addr; exp_mem_wdata = cur_wdata;
    free_edge = e + 3;
  endtask

  task automatic tick();
    int   e;
    logic rst_now, acc, rsp, sel0, sel1;
    e = edge_n + 1;
    applyStimulus();
    rst_now = rst;
    if (rst_now) begin
      cur_valid = 1'b0; last_served = 1'b1; free_edge = e + 1;
      exp_mem_addr = '0; exp_mem_wdata = '0;
    end else if (e >= free_edge && (pend[0] || pend[1])) begin
      model_grant(e);
    end
    @(posedge clk);
    edge_n = e;
    #1;
    acc  = cur_valid && (e == cur_g);
    rsp  = cur_valid && (e == cur_g + 1);
    sel0 = rsp && !cur_m;
    sel1 = rsp && cur_m;
    checkOutput("done0", done0, sel0);
    checkOutput("done1", done1, sel1);
    checkOutput("err0", err0, sel0 ? cur_oor : 1'b0);
    checkOutput("err1", err1, sel1 ? cur_oor : 1'b0);
    checkOutput("rdata0", rdata0, sel0 ? cur_rdata : 32'd0);
    checkOutput("rdata1", rdata1, sel1 ? cur_rdata : 32'd0);
    checkOutput("mem_read", mem_read, acc && !cur_we && !cur_oor);
    checkOutput("mem_write", mem_write, acc && cur_we && !cur_oor);
    checkOutput("mem_addr", mem_addr, exp_mem_addr);
    checkOutput("mem_wdata", mem_wdata, exp_mem_wdata);
    checkOutput("busy", busy, acc || rsp);
    checkOutput("rd_wr_excl", mem_read & mem_write, 1'b0);
    if (mem_write) wr_seen++;
    if (mem_read) rd_seen++;
    if (done0) begin obs_m.push_back(0); obs_edge.push_back(e + 1); end
    if (done1) begin obs_m.push_back(1); obs_edge.push_back(e + 1); end
    if (rst_now) begin
      pend[0] = 1'b0; pend[1] = 1'b0;
    end else if (rsp) begin
      pend[cur_m] = 1'b0;
      if (keep[cur_m]) gen_txn(int'(cur_m));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    random_mode = 1'b0;
    rst = 1'b0;
    while ((pend[0] || pend[1]) && n < 40) begin
      tick();
      n++;
    end
    checkOutput("drain_timeout", pend[0] || pend[1], 1'b0);
    tick();
    tick();
  endtask

  initial begin
    int s;
    int exp_order [4];
    int exp_off [4];
    exp_order = '{0, 1, 0, 1};
    exp_off   = '{2, 5, 8, 11};
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    // reset with preload, then reset dominating a live request
    rst = 1'b1;
    tick();
    preload = 1'b0;
    set_txn(0, 1'b0, 32'd9, 32'd0);
    tick();
    rst = 1'b0;

    // single read of the preloaded word at address 5
    set_txn(0, 1'b0, 32'd5, 32'd0);
    drain();

    // master 1 writes then reads back address 2000
    wr_seen = 0;
    set_txn(1, 1'b1, 32'd2000, 32'h12345678);
    drain();
    set_txn(1, 1'b0, 32'd2000, 32'd0);
    drain();
    checkOutput("wr_pulses", wr_seen, 32'd1);

    // out-of-range read and write
    wr_seen = 0; rd_seen = 0;
    set_txn(1, 1'b0, 32'd4096, 32'd0);
    drain();
    set_txn(1, 1'b1, 32'd4096, 32'hA5A5A5A5);
    drain();
    checkOutput("oor_wr_pulses", wr_seen, 32'd0);
    checkOutput("oor_rd_pulses", rd_seen, 32'd0);

    // contention straight out of reset; offsets are the edges at which a master sees done
    rst = 1'b1;
    tick();
    rst = 1'b0;
    obs_m.delete(); obs_edge.delete();
    keep[0] = 1'b1; keep[1] = 1'b1;
    set_txn(0, 1'b0, 32'd1, 32'd0);
    set_txn(1, 1'b0, 32'd2, 32'd0);
    s = edge_n + 1;
    for (int i = 0; i < 12; i++) tick();
    keep[0] = 1'b0; keep[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr_order%0d", i), (i < obs_m.size()) ? 32'(obs_m[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
      checkOutput($sformatf("rr_done_off%0d", i), (i < obs_edge.size()) ? 32'(obs_edge[i] - s) : 32'hFFFF_FFFF, 32'(exp_off[i]));
    end
    drain();

    // reset during the access cycle of a write abandons it and restores tie priority
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_txn(0, 1'b1, 32'd7, 32'hCAFEF00D);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    obs_m.delete(); obs_edge.delete();
    set_txn(0, 1'b0, 32'd7, 32'd0);
    set_txn(1, 1'b0, 32'd3, 32'd0);
    drain();
    checkOutput("tie_after_rst", (obs_m.size() > 0) ? 32'(obs_m[0]) : 32'hFFFF_FFFF, 32'd0);

    // randomized traffic with occasional resets
    random_mode = 1'b1;
    for (int i = 0; i < 800; i++) tick();
    drain();

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, 4096, number of 32-bit words in the shared memory; valid word addresses are 0..DEPTH-1.
REQ-002 SHALL have parameter AW, 12, log2(DEPTH), the address bits checked for range.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  transaction request from master 0 (instruction fetch) and master 1 (data access).
REQ-006 SHALL have ports we0/we1  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1  input  32  word address.
REQ-008 SHALL have ports wdata0/wdata1  input  32  write data.
REQ-009 SHALL have ports done0/done1  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports err0/err1  output  1  out-of-range flag, valid only with done.
REQ-011 SHALL have ports rdata0/rdata1  output  32  read data, valid only with done.
REQ-012 SHALL have port mem_addr  output  32  to memory Address.
REQ-013 SHALL have port mem_wdata  output  32  to memory Write_data.
REQ-014 SHALL have ports mem_read/mem_write  output  1  to memory Mem_read and Mem_write.
REQ-015 SHALL have port mem_rdata  input  32  from memory Mem_read_value, combinational.
REQ-016 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-017 SHALL implement a 3-state FSM: IDLE -> ACCESS -> RESP -> IDLE.
REQ-018 In IDLE with any req high, SHALL select one master and latch its we, addr and wdata, plus an out-of-range bit (addr[31:AW] != 0), then go to ACCESS.
REQ-019 In IDLE with no req high, SHALL remain in IDLE.
REQ-020 Selection SHALL be round-robin: if both req are high, grant the master not served last; after reset, master 0 wins the first tie.
REQ-021 With a single request, SHALL grant it regardless of the round-robin pointer; the pointer updates only on a grant.
REQ-022 In ACCESS, SHALL drive mem_addr and mem_wdata from the latched values.
REQ-023 In ACCESS, SHALL drive mem_read = !we & !oor and mem_write = we & !oor.
REQ-024 In all other states, mem_read and mem_write SHALL be 0 and mem_addr and mem_wdata SHALL hold their last values.
REQ-025 At the end of ACCESS, SHALL register mem_rdata for a read, or 0 for a write or an out-of-range access.
REQ-026 In RESP, SHALL pulse done of the served master only, for exactly 1 cycle, with err = oor and rdata = the registered value.
REQ-027 The unserved master's done, err and rdata SHALL be 0.
REQ-028 Latency SHALL be fixed: done rises 2 cycles after the IDLE edge that samples req; throughput is one transaction per 3 cycles.
REQ-029 Masters SHALL hold req, we, addr and wdata stable until done, and drop req in the cycle after done unless issuing a new transaction.
REQ-030 Changes on the unselected master's inputs SHALL NOT affect an in-flight transaction.
REQ-031 An out-of-range access SHALL NOT assert mem_read or mem_write.
REQ-032 Memory SHALL never see mem_read and mem_write high together.
REQ-033 A request arriving while busy SHALL wait, sampled at the next IDLE edge; no request is dropped.
REQ-034 Round-robin SHALL bound the wait: with both masters requesting continuously, each master is served at least every 6 cycles.

Reset
REQ-035 On a posedge with rst high, SHALL set state to IDLE and the round-robin pointer to "master 1 last".
REQ-036 On that reset edge, SHALL clear done0/1, err0/1, rdata0/1, mem_read, mem_write, mem_addr, mem_wdata and busy to 0.
REQ-037 Reset mid-transaction SHALL abandon it: no done pulse, and no mem_write in the cycle after the reset edge.
REQ-038 rst SHALL dominate req in the same cycle.

Verification
REQ-039 Single read: memory[5]=0xDEADBEEF; req0=1, we0=0, addr0=5 at IDLE -> mem_read=1 with mem_addr=5 next cycle; done0=1, rdata0=0xDEADBEEF 2 cycles after sampling; done1 stays 0.
REQ-040 Write then read: master 1 writes 0x12345678 to addr 2000, then reads addr 2000 -> mem_write=1 for exactly 1 cycle; read returns 0x12345678; err1=0 both times.
REQ-041 Contention: req0 and req1 held high for 4 transactions from reset -> grant order 0,1,0,1; done pulses at cycles 2,5,8,11 after first sample.
REQ-042 Out of range: addr1=4096, read and write -> mem_read=mem_write=0 throughout; done1=1, err1=1, rdata1=0.
REQ-043 Reset mid-op: assert rst during ACCESS of a write to addr 7 holding 0 -> memory[7] unchanged if rst precedes the write edge; no done; busy=0 next cycle; next request gets master-0 tie priority.
